hazard_fwd_unit: RTL
====================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have parameter X0_ZERO, default 1, meaning address 0 is hardwired and never forwards or stalls.
REQ-004 SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  async active-low reset.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 id_rs1, id_rs2  input  REG_AW  ID source addresses.
REQ-009 id_rs1_used, id_rs2_used  input  1  the source is actually read.
REQ-010 id_rd  input  REG_AW  ID destination.
REQ-011 id_reg_write, id_is_load  input  1  ID writes rd / is a load.
REQ-012 ex_flush  input  1  taken branch in EX; kill the ID and EX instructions.
REQ-013 mem_busy  input  1  data memory not ready; freeze the whole pipeline.
REQ-014 stall  output  1  hold PC and IF/ID (combinational).
REQ-015 fwd_a, fwd_b  output  2  operand select for the instruction in EX (registered).
REQ-016 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-017 SHALL keep three internal shadow stages, EX, MEM and WB, each holding {valid, rd, reg_write, is_load}.
REQ-018 A producer SHALL qualify only if: valid=1, reg_write=1, rd==rs, rs_used=1, and not (X0_ZERO and rd==0).
REQ-019 Forward encoding SHALL be: 00 regfile; 01 EX/MEM result; 10 MEM/WB result; 11 reserved, never driven.
REQ-020 Forward selects SHALL be computed from ID inputs versus the EX and MEM shadows, and registered into fwd_a/fwd_b when ID advances.
REQ-021 Selection rules: EX-shadow match gives 01; otherwise MEM-shadow match gives 10; otherwise 00. The newer producer wins.
REQ-022 Each operand SHALL be evaluated independently; both may select the same source.
REQ-023 Load-use: stall=1 when id_valid=1 and a qualifying EX-shadow producer has is_load=1.
REQ-024 A load-use stall SHALL last exactly one cycle. A bubble (valid=0, fwd 00) enters the EX shadow while MEM and WB advance. The retried ID then gets 10.
REQ-025 stall SHALL also equal 1 whenever mem_busy=1.
REQ-026 When mem_busy=1, all shadows, fwd_a and fwd_b SHALL hold their values; ex_flush is ignored that cycle.
REQ-027 When ex_flush=1 and mem_busy=0:
- the EX shadow loads a bubble;
- the old EX content does not advance to MEM;
- stall is forced to 0, which cancels any load-use stall;
- fwd_a/fwd_b load 00.
REQ-028 On a normal advance (no stall, no flush): ID moves to EX, EX to MEM, MEM to WB. id_valid=0 moves in as a bubble.
REQ-029 stall_cnt SHALL increment by 1 on every cycle with stall=1 and saturate at all-ones.
REQ-030 stall SHALL be asserted in the same cycle as the hazard (zero latency). fwd_a/fwd_b SHALL be valid in the cycle the consumer is in EX (one-cycle latency from ID).

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all shadow valid bits, fwd_a=00, fwd_b=00 and stall_cnt=0; stall therefore reads 0.
REQ-032 Reset asserted mid-stall or mid-freeze SHALL abort it. After release, the first instruction is treated as a fresh ID with no history.
REQ-033 Reset deassertion SHALL take effect on the first rising edge of clk after rst_n goes high.

Structure
REQ-034 A shared package hazard_pkg SHALL hold the fwd select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the shadow-stage struct type.
REQ-035 One sub-module, hazard_stage_reg, SHALL implement a single shadow stage with load, bubble and hold controls. It is instantiated three times.

Verification
REQ-036 Back-to-back ALU: add x3 then sub x5,x3,x3 -> fwd_a=01, fwd_b=01 in sub's EX cycle, stall=0.
REQ-037 Distance 2: add x3; nop; or x6,x3,x4 -> fwd_a=10, fwd_b=00.
REQ-038 Double producer: add x3; add x3; use x3 -> fwd_a=01, the newer producer wins over 10.
REQ-039 Load-use: lw x7; add x8,x7,x1 -> stall=1 for exactly 1 cycle, then fwd_a=10 and stall_cnt=1.
REQ-040 x0 and flush cases:
- add x0 then use x0 -> fwd 00, stall 0;
- lw x7 with ex_flush in the hazard cycle -> stall=0 and the bubble leaves no forward.
REQ-041 Freeze and reset cases:
- mem_busy high for 3 cycles during a load-use hazard -> shadows hold, stall=1 for 3+1 cycles, stall_cnt=4;
- rst_n pulsed mid-freeze -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared forward-select encodings, shadow-stage record and the
//               producer-qualification rule used by the hazard/forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Shadow records carry rd at this fixed width; narrower REG_AW values are zero-extended.
    localparam int MAX_REG_AW = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } stage_t;

    function automatic logic qualifies(
        input stage_t                s,
        input logic [MAX_REG_AW-1:0] rs,
        input logic                  rs_used,
        input logic                  x0_zero
    );
        return s.valid && s.reg_write && rs_used && (s.rd == rs) &&
               !(x0_zero && (rs == '0));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stage_reg.sv
// ============================================================================
// Module      : hazard_stage_reg
// Description : One shadow pipeline stage with hold, bubble and load controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   bubble,
    input  logic   hold,
    input  stage_t d,
    output stage_t q
);

    // Priority: hold beats bubble beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                q <= '0;
            end else if (load) begin
                q <= d;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module      : hazard_fwd_unit
// Description : Load-use stall detection and EX operand forwarding selects
//               for a classic five-stage pipeline, with flush and freeze.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter bit X0_ZERO = 1'b1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [MAX_REG_AW-1:0] rs1_ext;
    logic [MAX_REG_AW-1:0] rs2_ext;
    stage_t                id_stage;
    stage_t                ex_q;
    stage_t                mem_q;
    stage_t                wb_q;
    logic                  load_use;
    logic                  lu_stall;
    logic                  ex_bubble;
    logic [1:0]            fwd_a_nxt;
    logic [1:0]            fwd_b_nxt;
    logic                  unused_wb;

    assign rs1_ext  = MAX_REG_AW'(id_rs1);
    assign rs2_ext  = MAX_REG_AW'(id_rs2);
    assign id_stage = '{valid:     id_valid,
                        rd:        MAX_REG_AW'(id_rd),
                        reg_write: id_reg_write,
                        is_load:   id_is_load};

    assign load_use = id_valid && ex_q.is_load &&
                      (qualifies(ex_q, rs1_ext, id_rs1_used, X0_ZERO) ||
                       qualifies(ex_q, rs2_ext, id_rs2_used, X0_ZERO));

    // A taken branch kills the dependent ID instruction, so it cancels the load-use stall.
    assign lu_stall  = load_use && !ex_flush;
    assign stall     = rst_n && (mem_busy || lu_stall);
    assign ex_bubble = ex_flush || lu_stall || !id_valid;

    // The newer (EX) producer takes precedence over the older (MEM) one.
    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (qualifies(ex_q, rs1_ext, id_rs1_used, X0_ZERO)) begin
            fwd_a_nxt = FWD_EXMEM;
        end else if (qualifies(mem_q, rs1_ext, id_rs1_used, X0_ZERO)) begin
            fwd_a_nxt = FWD_MEMWB;
        end
        if (qualifies(ex_q, rs2_ext, id_rs2_used, X0_ZERO)) begin
            fwd_b_nxt = FWD_EXMEM;
        end else if (qualifies(mem_q, rs2_ext, id_rs2_used, X0_ZERO)) begin
            fwd_b_nxt = FWD_MEMWB;
        end
    end

    hazard_stage_reg u_ex_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (ex_bubble),
        .hold   (mem_busy),
        .d      (id_stage),
        .q      (ex_q)
    );

    hazard_stage_reg u_mem_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (ex_flush),
        .hold   (mem_busy),
        .d      (ex_q),
        .q      (mem_q)
    );

    hazard_stage_reg u_wb_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .hold   (mem_busy),
        .d      (mem_q),
        .q      (wb_q)
    );

    // WB is tracked for completeness of the shadow pipeline; nothing forwards from it.
    assign unused_wb = ^wb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (!mem_busy) begin
            if (ex_bubble) begin
                fwd_a <= FWD_RF;
                fwd_b <= FWD_RF;
            end else begin
                fwd_a <= fwd_a_nxt;
                fwd_b <= fwd_b_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
